// File: rtl/divider_ctrl_if.sv
// -----------------------------------------------------------------------------
// divider_ctrl_if : request/status and datapath-control bundle of divider_ctrl
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

interface divider_ctrl_if #(
  parameter int CW = 7
);
  logic          start;
  logic          abort;
  logic          ack;
  logic          cnt_is_0;
  logic          divisor_is_0;
  logic          dvsr_less_than_dvnd;
  logic          shifted_divisor_MSB;
  logic          init;
  logic          left;
  logic          right;
  logic          sub;
  logic          ready;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [CW-1:0] cyc_cnt;

  // master: requester plus datapath status side; slave: the sequencer
  modport master (
    output start, abort, ack,
    output cnt_is_0, divisor_is_0, dvsr_less_than_dvnd, shifted_divisor_MSB,
    input  init, left, right, sub,
    input  ready, busy, done, div_by_zero, cyc_cnt
  );

  modport slave (
    input  start, abort, ack,
    input  cnt_is_0, divisor_is_0, dvsr_less_than_dvnd, shifted_divisor_MSB,
    output init, left, right, sub,
    output ready, busy, done, div_by_zero, cyc_cnt
  );
endinterface

`default_nettype wire

// File: rtl/divider_ctrl.sv
// -----------------------------------------------------------------------------
// divider_ctrl : sequencing FSM for the shift/subtract long-division datapath
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module divider_ctrl #(
  parameter  int SIZE = 32,
  localparam int CW   = $clog2(3*SIZE+6)
) (
  input wire            clk,
  input wire            reset,
  divider_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CHECK   = 3'd2,
    S_ALIGN   = 3'd3,
    S_COMPARE = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_div_by_zero;
  logic [CW-1:0] r_cyc_cnt;

  logic          w_in_op;
  logic          w_counting;
  logic          w_abort;
  logic          w_align_shift;
  logic          w_init;
  logic          w_left;
  logic          w_right;
  logic          w_sub;

  assign w_in_op       = (r_state == S_LOAD) || (r_state == S_CHECK) ||
                         (r_state == S_ALIGN) || (r_state == S_COMPARE) ||
                         (r_state == S_NEXT);
  assign w_counting    = w_in_op && (r_state != S_LOAD);
  assign w_abort       = w_in_op && bus.abort;
  // The MSB stop keeps the shifted divisor from overflowing the register.
  assign w_align_shift = !bus.shifted_divisor_MSB && bus.dvsr_less_than_dvnd;

  always_comb begin
    w_init  = 1'b0;
    w_left  = 1'b0;
    w_right = 1'b0;
    w_sub   = 1'b0;
    if (!w_abort) begin
      case (r_state)
        S_LOAD:    w_init  = 1'b1;
        S_ALIGN:   w_left  = w_align_shift;
        S_COMPARE: w_sub   = bus.dvsr_less_than_dvnd;
        S_NEXT:    w_right = !bus.cnt_is_0;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = S_LOAD;
      S_LOAD:    w_next = S_CHECK;
      S_CHECK:   w_next = bus.divisor_is_0 ? S_ERR : S_ALIGN;
      S_ALIGN:   if (!w_align_shift) w_next = S_COMPARE;
      S_COMPARE: w_next = S_NEXT;
      S_NEXT:    w_next = bus.cnt_is_0 ? S_DONE : S_COMPARE;
      S_DONE:    if (bus.ack) w_next = S_IDLE;
      S_ERR:     if (bus.ack) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Status flags are registered copies of the decode of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_cyc_cnt     <= '0;
    end else begin
      r_state       <= w_next;
      r_ready       <= (w_next == S_IDLE);
      r_busy        <= (w_next == S_LOAD) || (w_next == S_CHECK) ||
                       (w_next == S_ALIGN) || (w_next == S_COMPARE) ||
                       (w_next == S_NEXT);
      r_done        <= (w_next == S_DONE) || (w_next == S_ERR);
      r_div_by_zero <= (w_next == S_ERR);
      if (!w_abort) begin
        if (r_state == S_LOAD) begin
          r_cyc_cnt <= CW'(1);
        end else if (w_counting && (r_cyc_cnt != {CW{1'b1}})) begin
          r_cyc_cnt <= r_cyc_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.init        = w_init;
  assign bus.left        = w_left;
  assign bus.right       = w_right;
  assign bus.sub         = w_sub;
  assign bus.ready       = r_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.cyc_cnt     = r_cyc_cnt;

endmodule

`default_nettype wire
